// File: rtl/vram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : vram_scan_reader
// Function : Burst reader for the VRAM B port feeding a valid/ready FIFO.
// Revision : 1.0
// ============================================================================
module vram_scan_reader #(
    parameter int ADDR_DEPTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_DEPTH-1:0] base_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_DEPTH-1:0] ba_o,
    input  logic [DATA_WIDTH-1:0] bo_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  dvalid_o,
    input  logic                  dready_i
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               OCC_W    = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_DEPTH-1:0]   ba_q;
    logic [CNT_WIDTH-1:0]    rem_q;
    logic                    tag_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_q;
    logic [PTR_W-1:0]        rd_q;
    logic [OCC_W-1:0]        occ_q;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    drained;
    logic [OCC_W-1:0]        committed;

    // Credit counts every FIFO slot already claimed: stored words plus the
    // read whose data is on BO this cycle. A same-cycle pop frees nothing yet.
    always_comb begin
        pop       = (occ_q != '0) && dready_i;
        push      = tag_q;
        committed = occ_q + OCC_W'(tag_q);
        issue     = (state_q == S_FETCH) && (rem_q != '0) &&
                    (committed < OCC_FULL) && !abort_i;
        drained   = !tag_q && (rem_q == '0) &&
                    ((occ_q == '0) || ((occ_q == OCC_W'(1)) && pop));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ba_q    <= '0;
            rem_q   <= '0;
            tag_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            tag_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tag_q  <= issue;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        rem_q  <= count_i;
                        // Zero-length bursts pass through DRAIN, which is
                        // trivially satisfied, so DONE lands one cycle later.
                        if (count_i == '0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            ba_q    <= base_i;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        ba_q  <= ba_q + ADDR_DEPTH'(1);
                        rem_q <= rem_q - CNT_WIDTH'(1);
                        if (rem_q == CNT_WIDTH'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else if (abort_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= bo_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign ba_o     = ba_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign do_o     = mem_q[rd_q];
    assign dvalid_o = (occ_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_vram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_scan_reader
// Function : Randomized scoreboard bench for vram_scan_reader.
// Revision : 1.0
// ============================================================================
module tb_vram_scan_reader;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int FD = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic          dready = 1'b1;
    logic [AW-1:0] base   = '0;
    logic [CW-1:0] count  = '0;
    logic          busy;
    logic          done;
    logic          dvalid;
    logic [AW-1:0] ba;
    logic [DW-1:0] dout;
    logic [DW-1:0] bo;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_e;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int pops      = 0;
    int dr_mode   = 0;
    int dr_phase  = 0;

    vram_scan_reader #(
        .ADDR_DEPTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .abort_i (abort),
        .base_i  (base),
        .count_i (count),
        .busy_o  (busy),
        .done_o  (done),
        .ba_o    (ba),
        .bo_i    (bo),
        .do_o    (dout),
        .dvalid_o(dvalid),
        .dready_i(dready)
    );

    always #5 clk = ~clk;

    // Synchronous-read VRAM B port model.
    always @(posedge clk) bo <= ram[ba];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never ready.
    always @(posedge clk) begin
        #1;
        case (dr_mode)
            0:       dready = 1'b1;
            1: begin
                dready   = ((dr_phase % 4) == 0) || ((dr_phase % 4) == 3);
                dr_phase = dr_phase + 1;
            end
            2:       dready = 1'($urandom_range(0, 1));
            default: dready = 1'b0;
        endcase
    end

    // Monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dvalid && dready) begin
                pops = pops + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'h0, dout}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_order", {24'h0, dout}, {24'h0, mon_e});
                end
            end
            if (done) begin
                done_seen = done_seen + 1;
                check("done_busy_low", {31'h0, busy}, 32'h0);
                check("done_all_delivered", exp_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_start(input logic [AW-1:0] b, input logic [CW-1:0] n, input bit accept);
        start = 1'b1;
        base  = b;
        count = n;
        if (accept) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back(ram[AW'(int'(b) + i)]);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no DONE within %0d cycles", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            cyc;
        int            d0;
        int            p0;
        int            adv;
        logic [AW-1:0] prev;
        logic [AW-1:0] step;
        logic [AW-1:0] b;
        logic [CW-1:0] n;

        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #2;
        check("reset_ba", {21'h0, ba}, 32'h0);
        check("reset_do", {24'h0, dout}, 32'h0);
        check("reset_dvalid", {31'h0, dvalid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic burst and latency.
        for (int i = 0; i < 4; i++) ram[12'h100 + i] = 8'hA0 + 8'(i);
        dr_mode = 0;
        d0 = done_seen;
        issue_start(11'h100, 8'd4, 1'b1);
        check("t1_ba_edge0", {21'h0, ba}, 32'h100);
        check("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        check("t1_dvalid_edge1", {31'h0, dvalid}, 32'h0);
        tick();
        check("t1_dvalid_edge2", {31'h0, dvalid}, 32'h1);
        check("t1_do_edge2", {24'h0, dout}, 32'hA0);
        wait_done(20, cyc);
        check("t1_done_edge", cyc + 2, 6);
        tick();
        check("t1_done_one_cycle", {31'h0, done}, 32'h0);
        check("t1_done_count", done_seen - d0, 1);

        // Address wrap.
        issue_start(11'h7FE, 8'd4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("t2_ba_seq", {21'h0, ba}, 32'(AW'(11'h7FE + k)));
            tick();
        end
        wait_done(20, cyc);
        tick();

        // Backpressure with BA step and outstanding-read bound.
        dr_mode  = 1;
        dr_phase = 0;
        p0  = pops;
        adv = 0;
        issue_start(11'h3C0, 8'd10, 1'b1);
        prev = ba;
        cyc  = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            step = ba - prev;
            check("t3_ba_step", {31'h0, (step <= AW'(1))}, 32'h1);
            adv += int'(step);
            prev = ba;
            check("t3_outstanding", {31'h0, ((adv - (pops - p0)) <= FD)}, 32'h1);
        end
        check("t3_done_seen", {31'h0, done}, 32'h1);
        check("t3_ba_advance", adv, 10);
        check("t3_pops", pops - p0, 10);
        tick();
        dr_mode = 0;

        // Zero-length burst.
        prev = ba;
        d0   = done_seen;
        issue_start(11'h055, 8'd0, 1'b1);
        check("t4_zero_busy", {31'h0, busy}, 32'h1);
        tick();
        check("t4_zero_done", {31'h0, done}, 32'h1);
        check("t4_zero_ba", {21'h0, ba}, {21'h0, prev});
        check("t4_zero_dvalid", {31'h0, dvalid}, 32'h0);
        tick();
        check("t4_zero_done_once", done_seen - d0, 1);

        // START while busy is ignored.
        d0 = done_seen;
        issue_start(11'h200, 8'd6, 1'b1);
        tick();
        tick();
        start = 1'b1;
        base  = 11'h300;
        count = 8'd5;
        tick();
        start = 1'b0;
        wait_done(30, cyc);
        check("t4_busy_start_edge", cyc + 3, 8);
        repeat (4) tick();
        check("t4_busy_start_done", done_seen - d0, 1);
        check("t4_busy_start_idle", {31'h0, dvalid}, 32'h0);

        // Abort mid-burst.
        d0 = done_seen;
        issue_start(11'h400, 8'd8, 1'b1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("t5_abort_dvalid", {31'h0, dvalid}, 32'h0);
        check("t5_abort_busy", {31'h0, busy}, 32'h0);
        repeat (6) tick();
        check("t5_abort_no_done", done_seen - d0, 0);
        check("t5_abort_quiet", {31'h0, dvalid}, 32'h0);
        ram[12'h020] = 8'h3C;
        ram[12'h021] = 8'hC3;
        p0 = pops;
        issue_start(11'h020, 8'd2, 1'b1);
        wait_done(20, cyc);
        check("t5_restart_pops", pops - p0, 2);
        tick();

        // ABORT and START together in IDLE.
        abort = 1'b1;
        start = 1'b1;
        base  = 11'h010;
        count = 8'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t5_abort_start_busy", {31'h0, busy}, 32'h0);
            check("t5_abort_start_dvalid", {31'h0, dvalid}, 32'h0);
            tick();
        end

        // Asynchronous reset while draining.
        dr_mode = 3;
        ram[12'h500] = 8'h5A;
        ram[12'h501] = 8'h5B;
        ram[12'h502] = 8'h5C;
        issue_start(11'h500, 8'd3, 1'b1);
        repeat (5) tick();
        check("t6_pre_dvalid", {31'h0, dvalid}, 32'h1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_ba", {21'h0, ba}, 32'h0);
        check("t6_rst_do", {24'h0, dout}, 32'h0);
        check("t6_rst_dvalid", {31'h0, dvalid}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_done", {31'h0, done}, 32'h0);
        tick();
        tick();
        rst_n   = 1'b1;
        dr_mode = 0;
        tick();
        issue_start(11'h600, 8'd5, 1'b1);
        wait_done(20, cyc);
        check("t6_after_reset_edge", cyc, 7);
        tick();

        // Randomized bursts under random backpressure.
        dr_mode = 2;
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom_range(0, (1 << AW) - 1));
            n = CW'($urandom_range(1, 24));
            p0 = pops;
            issue_start(b, n, 1'b1);
            wait_done(400, cyc);
            check("rand_pops", pops - p0, int'(n));
            tick();
        end
        dr_mode = 0;
        repeat (3) tick();

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
